// File: rtl/intr_priority_core.sv
// Priority interrupt controller: IRR/ISR/IMR registers, two-INTA acknowledge FSM, EOI/AEOI.
// Optional rotating priority is compiled in when INTR_ROTATE_EN is defined.
module intr_priority_core #(
    parameter int N_IRQ = 8,
    parameter int ID_W  = $clog2(N_IRQ)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_IRQ-1:0]  i_irq,
    input  logic              i_level,
    input  logic              i_imr_we,
    input  logic [N_IRQ-1:0]  i_imr_data,
    input  logic              i_aeoi,
    input  logic              i_eoi,
    input  logic              i_rotate,
    input  logic              i_inta_n,
    output logic              o_int,
    output logic [ID_W-1:0]   o_vector_id,
    output logic              o_vector_valid,
    output logic              o_spurious,
    output logic [N_IRQ-1:0]  o_irr,
    output logic [N_IRQ-1:0]  o_isr,
    output logic [N_IRQ-1:0]  o_imr,
    output logic [1:0]        o_inta_count
);

    typedef enum logic [1:0] {S_IDLE, S_ACK1, S_ACK2} state_t;

    state_t             r_state;
    logic [N_IRQ-1:0]   r_irq_q, r_irr, r_isr, r_imr;
    logic               r_inta_q, r_int, r_vector_valid, r_spurious, r_win_valid;
    logic [ID_W-1:0]    r_winner, r_vector_id;
    logic [1:0]         r_inta_count;

    logic [ID_W-1:0]    w_base;
    logic [N_IRQ-1:0]   w_req, w_isr_post, w_isr_next, w_irr_clr;
    logic [2*ID_W:0]    w_isr_pick, w_post_pick, w_req_pick;
    logic               w_isr_any, w_post_any, w_req_any, w_grant;
    logic [ID_W-1:0]    w_isr_id, w_req_id, w_post_rank, w_req_rank;
    logic               w_inta_fall, w_ack1, w_ack2, w_eoi_hit, w_aeoi_hit;
    logic [2*ID_W-1:0]  w_unused_pick;

    // Returns {found, rank, index} of the highest-priority set bit, rank 0 = index w_base.
    function automatic logic [2*ID_W:0] f_pick(input logic [N_IRQ-1:0] vec,
                                                input logic [ID_W-1:0]  base);
        logic [2*ID_W:0] res;
        logic [ID_W:0]   sum;
        res = '0;
        for (int k = N_IRQ - 1; k >= 0; k--) begin
            sum = {1'b0, base} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(N_IRQ))
                sum = sum - (ID_W+1)'(N_IRQ);
            if (vec[sum[ID_W-1:0]])
                res = {1'b1, ID_W'(k), sum[ID_W-1:0]};
        end
        return res;
    endfunction

    assign w_req       = r_irr & ~r_imr;
    assign w_isr_pick  = f_pick(r_isr, w_base);
    assign w_isr_any   = w_isr_pick[2*ID_W];
    assign w_isr_id    = w_isr_pick[ID_W-1:0];
    assign w_eoi_hit   = i_eoi & w_isr_any;
    // EOI lands before any same-cycle acknowledge resolution.
    assign w_isr_post  = w_eoi_hit ? (r_isr & ~(N_IRQ'(1) << w_isr_id)) : r_isr;
    assign w_post_pick = f_pick(w_isr_post, w_base);
    assign w_post_any  = w_post_pick[2*ID_W];
    assign w_post_rank = w_post_pick[2*ID_W-1:ID_W];
    assign w_req_pick  = f_pick(w_req, w_base);
    assign w_req_any   = w_req_pick[2*ID_W];
    assign w_req_rank  = w_req_pick[2*ID_W-1:ID_W];
    assign w_req_id    = w_req_pick[ID_W-1:0];
    assign w_grant     = w_req_any & (~w_post_any | (w_req_rank < w_post_rank));
    assign w_unused_pick = {w_isr_pick[2*ID_W-1:ID_W], w_post_pick[ID_W-1:0]};

    assign w_inta_fall = r_inta_q & ~i_inta_n;
    assign w_ack1      = (r_state == S_IDLE) & w_inta_fall;
    assign w_ack2      = (r_state == S_ACK1) & w_inta_fall;
    assign w_aeoi_hit  = w_ack2 & i_aeoi & r_win_valid;
    assign w_irr_clr   = (w_ack1 & w_grant) ? (N_IRQ'(1) << w_req_id) : '0;

    always_comb begin
        w_isr_next = w_isr_post;
        if (w_ack1 && w_grant)
            w_isr_next = w_isr_next | (N_IRQ'(1) << w_req_id);
        if (w_aeoi_hit)
            w_isr_next = w_isr_next & ~(N_IRQ'(1) << r_winner);
    end

`ifdef INTR_ROTATE_EN
    logic [ID_W-1:0] r_base;

    function automatic logic [ID_W-1:0] f_next(input logic [ID_W-1:0] id);
        return (id == ID_W'(N_IRQ - 1)) ? '0 : id + 1'b1;
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_base <= '0;
        else if (i_rotate && w_aeoi_hit)
            r_base <= f_next(r_winner);
        else if (i_rotate && w_eoi_hit)
            r_base <= f_next(w_isr_id);
    end
    assign w_base = r_base;
`else
    logic w_unused_rotate;
    assign w_unused_rotate = i_rotate;
    assign w_base = '0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_irq_q <= '0;
            r_irr   <= '0;
            r_imr   <= '1;
        end else begin
            r_irq_q <= i_irq;
            if (i_imr_we)
                r_imr <= i_imr_data;
            if (i_level)
                r_irr <= i_irq;
            else
                r_irr <= (r_irr & ~w_irr_clr) | (i_irq & ~r_irq_q);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_isr          <= '0;
            r_int          <= 1'b0;
            r_vector_id    <= '0;
            r_vector_valid <= 1'b0;
            r_spurious     <= 1'b0;
            r_inta_count   <= 2'd0;
            r_winner       <= '0;
            r_win_valid    <= 1'b0;
            r_inta_q       <= 1'b1;
        end else begin
            r_inta_q       <= i_inta_n;
            r_isr          <= w_isr_next;
            r_vector_valid <= 1'b0;
            r_spurious     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_inta_fall) begin
                        r_state      <= S_ACK1;
                        r_winner     <= w_req_id;
                        r_win_valid  <= w_grant;
                        r_int        <= 1'b0;
                        r_inta_count <= 2'd1;
                    end else begin
                        r_int        <= w_grant;
                        r_inta_count <= 2'd0;
                    end
                end
                S_ACK1: begin
                    r_int <= 1'b0;
                    if (w_inta_fall) begin
                        r_state        <= S_ACK2;
                        r_vector_id    <= r_win_valid ? r_winner : ID_W'(N_IRQ - 1);
                        r_vector_valid <= 1'b1;
                        r_spurious     <= ~r_win_valid;
                        r_inta_count   <= 2'd2;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_int        <= 1'b0;
                    r_inta_count <= 2'd0;
                end
            endcase
        end
    end

    assign o_int          = r_int;
    assign o_vector_id    = r_vector_id;
    assign o_vector_valid = r_vector_valid;
    assign o_spurious     = r_spurious;
    assign o_irr          = r_irr;
    assign o_isr          = r_isr;
    assign o_imr          = r_imr;
    assign o_inta_count   = r_inta_count;

endmodule

// File: doc/intr_priority_core.md
INTR_PRIORITY_CORE -- requirements
Module: intr_priority_core

Interface
REQ-001 SHALL have parameter N_IRQ, default 8, number of request channels (legal 2..32).
REQ-002 SHALL have parameter ID_W, default $clog2(N_IRQ), width of channel index.
REQ-003 CLK  in  1  sole clock; all state on rising edge.
REQ-004 RST  in  1  asynchronous, active-high reset.
REQ-005 IRQ  in  N_IRQ  raw request lines, bit i = IR i.
REQ-006 LEVEL  in  1  1 = level-triggered, 0 = rising-edge-triggered.
REQ-007 IMR_WE  in  1  one-cycle strobe; loads IMR from IMR_DATA.
REQ-008 IMR_DATA  in  N_IRQ  mask value, 1 = masked.
REQ-009 AEOI  in  1  1 = clear ISR bit automatically at end of 2nd INTA.
REQ-010 EOI  in  1  one-cycle non-specific end-of-interrupt strobe.
REQ-011 ROTATE  in  1  1 = rotate priority on EOI (honoured only with ROTATE_EN).
REQ-012 INTA_  in  1  active-low acknowledge from processor, synchronous to CLK.
REQ-013 INT  out  1  interrupt request to processor.
REQ-014 VECTOR_ID  out  ID_W  serviced channel index, valid with VECTOR_VALID.
REQ-015 VECTOR_VALID  out  1  one-cycle pulse on 2nd INTA_ falling edge.
REQ-016 SPURIOUS  out  1  qualifies VECTOR_VALID: no ISR bit was set.
REQ-017 IRR, ISR, IMR  out  N_IRQ each  register readback.
REQ-018 INTA_COUNT  out  2  acknowledges received in current sequence (0,1,2).

Function
REQ-019 Edge mode: IRR[i] SHALL set on cycle after IRQ[i] sampled 0 then 1; level mode: IRR[i] SHALL follow registered IRQ[i].
REQ-020 INT SHALL be registered, asserted the cycle after any unmasked IRR bit outranks the highest set ISR bit; INT latency from IRQ rise = 2 cycles.
REQ-021 Default priority SHALL be fully nested: lower index = higher priority; bit with equal or lower priority than in-service bit never raises INT.
REQ-022 FSM states IDLE, ACK1, ACK2; INTA_ falling edge detected by registered compare (high previous cycle, low now).
REQ-023 IDLE -> ACK1 on INTA_ falling edge: winner frozen, ISR[winner] set, IRR[winner] cleared (edge mode), INT deasserted, INTA_COUNT=1.
REQ-024 ACK1 -> ACK2 on next INTA_ falling edge: VECTOR_ID=winner, VECTOR_VALID=1 for one cycle, INTA_COUNT=2; if AEOI, ISR[winner] cleared same cycle.
REQ-025 ACK2 -> IDLE on next cycle; INTA_COUNT returns to 0.
REQ-026 If no unmasked request exists at 1st INTA_ edge (request withdrawn), ISR SHALL be unchanged and the 2nd INTA SHALL return VECTOR_ID=N_IRQ-1 with SPURIOUS=1.
REQ-027 EOI SHALL clear the highest-priority set ISR bit; EOI with ISR=0 SHALL do nothing.
REQ-028 EOI coincident with an INTA_ edge SHALL be applied first; resolution uses post-EOI ISR.
REQ-029 IMR_WE coincident with INTA_ edge SHALL use the old IMR for that resolution.
REQ-030 Masking a bit SHALL not clear its IRR or ISR bit.

Reset
REQ-031 On RST: IRR=0, ISR=0, IMR=all ones, INT=0, VECTOR_ID=0, VECTOR_VALID=0, SPURIOUS=0, INTA_COUNT=0, FSM=IDLE, rotation base=0, edge history=0.
REQ-032 RST mid-sequence SHALL abandon sequence; no VECTOR_VALID issued.

Configuration
REQ-033 Macro INTR_ROTATE_EN defined: when ROTATE=1, channel cleared by EOI/AEOI becomes lowest priority, next index (mod N_IRQ) highest.
REQ-034 INTR_ROTATE_EN undefined: ROTATE ignored, priority fixed fully nested, no rotation register synthesised.

Verification
REQ-035 N_IRQ=8, IMR=0x00, edge, pulse IRQ[2] -> INT high 2 cycles later; two INTA_ pulses -> VECTOR_ID=2, ISR=0x04, IRR=0x00.
REQ-036 ISR=0x04 pending, raise IRQ[5] -> INT stays 0; raise IRQ[1] -> INT=1, 2nd INTA gives VECTOR_ID=1, ISR=0x06.
REQ-037 AEOI=1, IRQ[3] serviced -> ISR=0x00 in VECTOR_VALID cycle.
REQ-038 IRQ[4] level, dropped after INT before 1st INTA_ -> VECTOR_ID=7, SPURIOUS=1, ISR=0x00.
REQ-039 INTR_ROTATE_EN, ROTATE=1, IRQ[0] serviced then EOI, IRQ[0] and IRQ[6] both pending -> VECTOR_ID=6.
REQ-040 RST asserted between 1st and 2nd INTA_ -> all outputs per REQ-031, no VECTOR_VALID; N_IRQ=16 rerun of REQ-035 with IRQ[12] -> VECTOR_ID=12.
